// File: rtl/hex_encoder_stream_if.sv
// ---------------------------------------------------------------------------
// hex_encoder_stream_if
//   Bundles the packet-in / character-out handshake of the hex encoder.
//   in_valid/in_ready/in_data : NBYTES-byte packet offered by the producer
//   out_valid/out_ready       : ASCII character stream towards the sink
//   out_char                  : one ASCII hex digit
//   out_last                  : marks the final digit of a packet
//   Modports: slave  = the encoder's view
//             master = the producer/sink (testbench) view
// ---------------------------------------------------------------------------
interface hex_encoder_stream_if #(
    parameter int NBYTES = 11
);
    logic                  in_valid;
    logic                  in_ready;
    logic [NBYTES*8-1:0]   in_data;
    logic                  out_valid;
    logic                  out_ready;
    logic [7:0]            out_char;
    logic                  out_last;

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_char, out_last
    );

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_char, out_last
    );
endinterface

// File: rtl/hex_encoder_stream.sv
// ---------------------------------------------------------------------------
// hex_encoder_stream
//   Latches an NBYTES-byte packet and emits it as 2*NBYTES ASCII hex digits,
//   byte 0 first, upper nibble before lower nibble.
//   Ports:
//     clk   : rising-edge clock
//     rst   : asynchronous active-high reset
//     bus   : hex_encoder_stream_if.slave (packet in, characters out)
//     busy  : a packet is latched and not yet fully emitted
//   Parameters:
//     NBYTES    : bytes per packet, 1..32
//     UPPERCASE : 0 -> 'a'..'f', 1 -> 'A'..'F'
// ---------------------------------------------------------------------------
module hex_encoder_stream #(
    parameter int NBYTES    = 11,
    parameter bit UPPERCASE = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst,
    hex_encoder_stream_if.slave   bus,
    output logic                  busy
);

    typedef enum logic {
        IDLE = 1'b0,
        EMIT = 1'b1
    } state_t;

    localparam int         NCHARS   = 2 * NBYTES;
    localparam logic [5:0] LAST_IDX = 6'(NCHARS - 1);

    state_t                r_state;
    logic [5:0]            r_idx;
    logic [NBYTES*8-1:0]   r_data;
    logic                  r_in_ready;
    logic                  r_out_valid;
    logic                  r_out_last;
    logic [7:0]            r_out_char;

    logic                  w_accept;
    logic                  w_out_hs;
    logic [5:0]            w_next_idx;
    logic [7:0]            w_next_byte;
    logic [3:0]            w_next_nib;

    function automatic logic [7:0] nib_to_ascii(input logic [3:0] n);
        if (n <= 4'd9) begin
            return 8'h30 + {4'h0, n};
        end
        return (UPPERCASE ? 8'h37 : 8'h57) + {4'h0, n};
    endfunction

    // The character register is loaded one step ahead: on accept it gets
    // digit 0, on each handshake it gets the digit for the next index.
    // NOTE: every signal assigned in always_comb gets a value on every path,
    // otherwise synthesis infers a latch to hold the old value.
    always_comb begin
        w_accept    = bus.in_valid && r_in_ready;
        w_out_hs    = r_out_valid && bus.out_ready;
        w_next_idx  = r_idx + 6'd1;
        w_next_byte = r_data[{w_next_idx[5:1], 3'b000} +: 8];
        w_next_nib  = w_next_idx[0] ? w_next_byte[3:0] : w_next_byte[7:4];
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    // NOTE: the packet register is cleared by reset as well, so no data from
    // an aborted packet survives; it is a plain register, not a RAM.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_idx       <= 6'd0;
            r_data      <= '0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            r_out_char  <= 8'h00;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_state     <= EMIT;
                        r_data      <= bus.in_data;
                        r_idx       <= 6'd0;
                        r_in_ready  <= 1'b0;
                        r_out_valid <= 1'b1;
                        r_out_char  <= nib_to_ascii(bus.in_data[7:4]);
                        // A packet always has at least two digits, so digit 0
                        // is never the last one.
                        r_out_last  <= 1'b0;
                    end
                end
                EMIT: begin
                    if (w_out_hs) begin
                        if (r_idx == LAST_IDX) begin
                            r_state     <= IDLE;
                            r_idx       <= 6'd0;
                            r_in_ready  <= 1'b1;
                            r_out_valid <= 1'b0;
                            r_out_last  <= 1'b0;
                            r_out_char  <= 8'h00;
                        end else begin
                            r_idx       <= w_next_idx;
                            r_out_char  <= nib_to_ascii(w_next_nib);
                            r_out_last  <= (w_next_idx == LAST_IDX);
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.in_ready  = r_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.out_char  = r_out_char;
    assign bus.out_last  = r_out_last;
    assign busy          = ~r_in_ready;

endmodule
